// File: rtl/joy_pkg.sv
// Shared constants for the serial joystick link: stream bit positions,
// default chain length and the encoder FSM state encoding.
package joy_pkg;

  localparam int JB_P1_FIRE2 = 0;
  localparam int JB_P1_FIRE1 = 1;
  localparam int JB_P1_RIGHT = 2;
  localparam int JB_P1_LEFT  = 3;
  localparam int JB_P1_DOWN  = 4;
  localparam int JB_P1_UP    = 5;
  localparam int JB_P2_FIRE2 = 6;
  localparam int JB_P2_FIRE1 = 7;
  localparam int JB_P2_RIGHT = 8;
  localparam int JB_P2_LEFT  = 9;
  localparam int JB_P2_DOWN  = 10;
  localparam int JB_P2_UP    = 11;
  localparam int JB_BUTTONS  = 12;

  localparam int CHAIN_BITS_DEF = 16;

  typedef enum logic [1:0] {
    JE_IDLE  = 2'd0,
    JE_LOAD  = 2'd1,
    JE_SHIFT = 2'd2
  } je_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with level, rise and fall
// outputs; RST_VAL is the idle level so leaving reset detects no edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/joyencoder.sv
// Device end of the serial joystick link: emulates a chained pair of
// parallel-load shift registers, clocked entirely from the system clock.
module joyencoder
  import joy_pkg::*;
#(
  parameter int CHAIN_BITS  = CHAIN_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_clk,
  input  logic       joy_load,
  input  logic       joy1up,
  input  logic       joy1down,
  input  logic       joy1left,
  input  logic       joy1right,
  input  logic       joy1fire1,
  input  logic       joy1fire2,
  input  logic       joy2up,
  input  logic       joy2down,
  input  logic       joy2left,
  input  logic       joy2right,
  input  logic       joy2fire1,
  input  logic       joy2fire2,
  output logic       joy_data,
  output logic [4:0] shift_count,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [4:0] FULL = 5'(CHAIN_BITS);

  logic clk_lvl, clk_rise, clk_fall;
  logic ld_hi, ld_rise, ld_fall, ld_lo;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk(clk), .reset(reset), .din(joy_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ld_sync (
    .clk(clk), .reset(reset), .din(joy_load),
    .level(ld_hi), .rise(ld_rise), .fall(ld_fall)
  );

  assign ld_lo = ~ld_hi;

  logic unused_edges;
  assign unused_edges = ^{clk_lvl, clk_fall, ld_fall};

  je_state_t                 state_q, state_d;
  logic [JB_BUTTONS-1:0]     btn_q, btn_d;
  logic [CHAIN_BITS-1:0]     sreg_q, sreg_d, load_img;
  logic [4:0]                cnt_q, cnt_d;
  logic                      fd_q, fd_d;
  logic                      ovr_q, ovr_d;

  always_comb begin
    btn_d              = '1;
    btn_d[JB_P1_FIRE2] = joy1fire2;
    btn_d[JB_P1_FIRE1] = joy1fire1;
    btn_d[JB_P1_RIGHT] = joy1right;
    btn_d[JB_P1_LEFT]  = joy1left;
    btn_d[JB_P1_DOWN]  = joy1down;
    btn_d[JB_P1_UP]    = joy1up;
    btn_d[JB_P2_FIRE2] = joy2fire2;
    btn_d[JB_P2_FIRE1] = joy2fire1;
    btn_d[JB_P2_RIGHT] = joy2right;
    btn_d[JB_P2_LEFT]  = joy2left;
    btn_d[JB_P2_DOWN]  = joy2down;
    btn_d[JB_P2_UP]    = joy2up;
  end

  always_comb begin
    load_img                 = '1;
    load_img[JB_BUTTONS-1:0] = btn_q;

    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    ovr_d   = ovr_q;

    // Load dominates in every state: a falling load mid-frame aborts it
    // and any clock rise in the same clk is dropped.
    if (ld_lo || state_q == JE_LOAD) begin
      sreg_d  = load_img;
      cnt_d   = '0;
      ovr_d   = 1'b0;
      state_d = ld_lo ? JE_LOAD : JE_SHIFT;
    end else begin
      case (state_q)
        JE_SHIFT: begin
          if (clk_rise && !ld_rise) begin
            if (cnt_q < FULL) begin
              sreg_d = {1'b1, sreg_q[CHAIN_BITS-1:1]};
              cnt_d  = cnt_q + 5'd1;
              fd_d   = (cnt_d == FULL);
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        JE_IDLE: ;
        default: state_d = JE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= JE_IDLE;
      btn_q   <= '1;
      sreg_q  <= '1;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign joy_data    = sreg_q[0];
  assign shift_count = cnt_q;
  assign frame_done  = fd_q;
  assign overrun     = ovr_q;

endmodule
